chunked_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder; parametrised successor to the 1-bit full-adder cell.

---
 rtl/chunked_serial_adder_if.sv | 40 ++++
 rtl/chunked_serial_adder.sv | 143 ++++++++++++++
 tb/tb_chunked_serial_adder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_serial_adder_if.sv
// Request/result bundle for chunked_serial_adder: start/busy/done handshake,
// operands and result. The sub select exists only when ADDER_SUB_EN is defined.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

`ifdef ADDER_SUB_EN
  modport master (
    output start, a, b, ci, sub,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, a, b, ci, sub,
    output busy, done, sum, co, ovf
  );
`else
  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co, ovf
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co, ovf
  );
`endif
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock, inter-chunk carry held in a register.
// Optional feature macro: ADDER_SUB_EN (adds the sub select, computing a + ~b + 1).
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  chunked_serial_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK:0]   chunk_add;
  logic [WIDTH-1:0] chunk_ext;
  logic             carry_into_msb;
  logic             last_chunk;

  // Subtraction is folded into the latched operand: B is stored inverted and the
  // carry register starts at 1, so the chunk datapath only ever adds.
  always_comb begin
`ifdef ADDER_SUB_EN
    b_eff   = bus.sub ? ~bus.b : bus.b;
    cin_eff = bus.sub ? 1'b1   : bus.ci;
`else
    b_eff   = bus.b;
    cin_eff = bus.ci;
`endif
  end

  // Operands shift right one chunk per cycle, so the active chunk is always
  // in the low CHUNK bits of a_q/b_q.
  always_comb begin
    chunk_add      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};
    chunk_ext      = WIDTH'(chunk_add[CHUNK-1:0]);
    // Carry into a bit is recoverable as a ^ b ^ sum of that bit.
    carry_into_msb = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_add[CHUNK-1];
    last_chunk     = (cnt_q == LAST_CNT);
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = BUSY;
          a_d     = bus.a;
          b_d     = b_eff;
          carry_d = cin_eff;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end

      BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Result chunks enter at the top and drift down to their final position.
        acc_d   = (acc_q >> CHUNK) | (chunk_ext << (WIDTH - CHUNK));
        carry_d = chunk_add[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (last_chunk) begin
          state_d = IDLE;
          cnt_d   = '0;
          sum_d   = acc_d;
          co_d    = chunk_add[CHUNK];
          ovf_d   = carry_into_msb ^ chunk_add[CHUNK];
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: an 8/4 instance (two chunks) and
// an 8/8 instance (single cycle), table vectors, corner sequences and random ops.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(8)) bus0 ();
  chunked_serial_adder_if #(.WIDTH(8)) bus1 ();

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  int total = 0;
  int bad   = 0;
  int overlap = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: whole-word arithmetic, overflow from operand/result sign rule.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic ci, input logic sub);
    logic [7:0] bb;
    logic       cin;
    logic [8:0] full;
    logic       v;
    bb   = sub ? ~b : b;
    cin  = sub ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
    v    = (a[7] == bb[7]) && (full[7] != a[7]);
    return {full[7:0], full[8], v};
  endfunction

  always @(negedge clk) begin
    if (bus0.busy && bus0.done) overlap++;
    if (bus1.busy && bus1.done) overlap++;
  end

  task automatic drive0(input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub);
    bus0.start = st;
    bus0.a     = a;
    bus0.b     = b;
    bus0.ci    = ci;
`ifdef ADDER_SUB_EN
    bus0.sub   = sub;
`endif
  endtask

  task automatic drive1(input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub);
    bus1.start = st;
    bus1.a     = a;
    bus1.b     = b;
    bus1.ci    = ci;
`ifdef ADDER_SUB_EN
    bus1.sub   = sub;
`endif
  endtask

  // Counts negedge samples until done; lat = completed edges after the reference edge.
  task automatic wait_done0(output int lat, output int busy_n, output bit seen);
    lat = 0; busy_n = 0; seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus0.done) begin
        seen = 1'b1;
        lat  = k - 1;
        break;
      end
      if (bus0.busy) busy_n++;
    end
  endtask

  task automatic wait_done1(output int lat, output int busy_n, output bit seen);
    lat = 0; busy_n = 0; seen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus1.done) begin
        seen = 1'b1;
        lat  = k - 1;
        break;
      end
      if (bus1.busy) busy_n++;
    end
  endtask

  task automatic do_op0(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub,
                        input logic [7:0] es, input logic eco, input logic eovf);
    int lat, busy_n;
    bit seen;
    @(negedge clk);
    drive0(1'b1, a, b, ci, sub);
    @(posedge clk);
    #1 drive0(1'b0, ~a, ~b, ~ci, ~sub);
    wait_done0(lat, busy_n, seen);
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_lat"},  32'(lat), 32'd2);
      check({tag, "_busy"}, 32'(busy_n), 32'd2);
      check({tag, "_sum"},  32'(bus0.sum), 32'(es));
      check({tag, "_co"},   32'(bus0.co), 32'(eco));
      check({tag, "_ovf"},  32'(bus0.ovf), 32'(eovf));
    end
  endtask

  task automatic do_op1(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub,
                        input logic [7:0] es, input logic eco, input logic eovf);
    int lat, busy_n;
    bit seen;
    @(negedge clk);
    drive1(1'b1, a, b, ci, sub);
    @(posedge clk);
    #1 drive1(1'b0, ~a, ~b, ~ci, ~sub);
    wait_done1(lat, busy_n, seen);
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_lat"},  32'(lat), 32'd1);
      check({tag, "_busy"}, 32'(busy_n), 32'd1);
      check({tag, "_sum"},  32'(bus1.sum), 32'(es));
      check({tag, "_co"},   32'(bus1.co), 32'(eco));
      check({tag, "_ovf"},  32'(bus1.ovf), 32'(eovf));
    end
  endtask

  initial begin
    int  lat, busy_n, dn;
    bit  seen;
    logic [7:0] ra, rb;
    logic       rci, rsub;
    logic [9:0] m;

    vecs[0] = '{"t1",     8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{"t2_pos", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{"t2_ci",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{"neg",    8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{"t6_a",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{"t6_b",   8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};

    rst_n = 1'b0;
    drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive1(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_sum",  32'(bus0.sum),  32'd0);
    check("rst_co",   32'(bus0.co),   32'd0);
    check("rst_ovf",  32'(bus0.ovf),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
`ifndef ADDER_SUB_EN
      if (vecs[i].sub) continue;
`endif
      do_op0(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
             vecs[i].s, vecs[i].co, vecs[i].ovf);
    end

    // T3: start held into BUSY is ignored; start in the done cycle is accepted.
    @(negedge clk);
    drive0(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive0(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    @(posedge clk);
    #1 drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done0(lat, busy_n, seen);
    check("t3_done", 32'(seen), 32'd1);
    check("t3_lat",  32'(lat), 32'd1);
    check("t3_sum",  32'(bus0.sum), 32'h30);
    check("t3_idle_in_done", 32'(bus0.busy), 32'd0);
    drive0(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_done0(lat, busy_n, seen);
    check("t3b_done", 32'(seen), 32'd1);
    check("t3b_lat",  32'(lat), 32'd2);
    check("t3b_sum",  32'(bus0.sum), 32'h02);

    // T4: asynchronous reset mid-operation.
    @(negedge clk);
    drive0(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive0(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_busy", 32'(bus0.busy), 32'd0);
    check("t4_done", 32'(bus0.done), 32'd0);
    check("t4_sum",  32'(bus0.sum),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus0.done) dn++;
    end
    check("t4_no_done", 32'(dn), 32'd0);
    do_op0("t4_after", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // T5: single-chunk instance.
    do_op1("t5", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
`ifdef ADDER_SUB_EN
      rsub = 1'($urandom);
`else
      rsub = 1'b0;
`endif
      m = model(ra, rb, rci, rsub);
      if (i % 4 == 3) do_op1("rnd1", ra, rb, rci, rsub, m[9:2], m[1], m[0]);
      else            do_op0("rnd0", ra, rb, rci, rsub, m[9:2], m[1], m[0]);
    end

    check("busy_done_exclusive", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
